// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file (mstatus, mtvec, mscratch, mepc, mcause,
// mvendorid, marchid) with Zicsr RW/RS/RC, trap entry, mret and PC redirect.
// Optional 64-bit mcycle/mcycleh counter is built when CSR_MCYCLE_EN is defined.
module csr_unit #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] MTVEC_RST = XLEN'(32'h8000_0000),
    parameter logic [XLEN-1:0] MARCHID   = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            csr_req,
    input  logic [1:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_cause,
    input  logic            mret_valid,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            mie_o
);

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_RW   = 2'b01,
        OP_RS   = 2'b10,
        OP_RC   = 2'b11
    } csr_op_e;

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MVENDORID = 12'hF11;
    localparam logic [11:0] A_MARCHID   = 12'hF12;
`ifdef CSR_MCYCLE_EN
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
`endif

    csr_op_e op;
    assign op = csr_op_e'(csr_op);

    logic            mie_q, mie_d;
    logic            mpie_q, mpie_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
`ifdef CSR_MCYCLE_EN
    logic [63:0]     cnt_q, cnt_d;
`endif

    logic [XLEN-1:0] old_val;
    logic [XLEN-1:0] mstatus_view;
    logic [XLEN-1:0] wval;
    logic            implemented;
    logic            read_only;
    logic            wants_write;
    logic            do_write;

    // mstatus as seen by software: MPP hardwired to M-mode, only MIE/MPIE live
    always_comb begin
        mstatus_view        = '0;
        mstatus_view[12:11] = 2'b11;
        mstatus_view[7]     = mpie_q;
        mstatus_view[3]     = mie_q;
    end

    // address decode: read value, implemented and read-only flags
    always_comb begin
        old_val     = '0;
        implemented = 1'b1;
        read_only   = 1'b0;
        case (csr_addr)
            A_MSTATUS:   old_val = mstatus_view;
            A_MTVEC:     old_val = mtvec_q;
            A_MSCRATCH:  old_val = mscratch_q;
            A_MEPC:      old_val = mepc_q;
            A_MCAUSE:    old_val = mcause_q;
            A_MVENDORID: read_only = 1'b1;
            A_MARCHID: begin
                old_val   = MARCHID;
                read_only = 1'b1;
            end
`ifdef CSR_MCYCLE_EN
            A_MCYCLE:    old_val = cnt_q[XLEN-1:0];
            A_MCYCLEH: begin
                if (XLEN == 32) old_val = XLEN'(cnt_q[63:32]);
                else            implemented = 1'b0;
            end
`endif
            default:     implemented = 1'b0;
        endcase
    end

    // write value and write qualification; RS/RC with a zero operand never writes
    always_comb begin
        wval = '0;
        case (op)
            OP_RW:   wval = csr_wdata;
            OP_RS:   wval = old_val | csr_wdata;
            OP_RC:   wval = old_val & ~csr_wdata;
            default: wval = old_val;
        endcase
        wants_write = (op == OP_RW) ||
                      (((op == OP_RS) || (op == OP_RC)) && (csr_wdata != '0));
        csr_illegal = rst_n && csr_req && (!implemented || (read_only && wants_write));
        // trap and mret each discard any same-cycle CSR write
        do_write    = rst_n && csr_req && wants_write && implemented && !read_only &&
                      !trap_valid && !mret_valid;
    end

    // combinational outputs: old value, redirect from pre-edge state
    always_comb begin
        csr_rdata      = csr_req ? old_val : '0;
        redirect_valid = rst_n && (trap_valid || mret_valid);
        redirect_pc    = trap_valid ? mtvec_q : mepc_q;
        mie_o          = mie_q;
    end

    // next-state: trap > mret > CSR write
    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        if (trap_valid) begin
            mepc_d   = {trap_pc[XLEN-1:2], 2'b00};
            mcause_d = trap_cause;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (mret_valid) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end else if (do_write) begin
            case (csr_addr)
                A_MSTATUS: begin
                    mie_d  = wval[3];
                    mpie_d = wval[7];
                end
                A_MTVEC:    mtvec_d    = {wval[XLEN-1:2], 2'b00};
                A_MSCRATCH: mscratch_d = wval;
                A_MEPC:     mepc_d     = {wval[XLEN-1:2], 2'b00};
                A_MCAUSE:   mcause_d   = wval;
                default:    ;
            endcase
        end
    end

`ifdef CSR_MCYCLE_EN
    // cycle counter: free-running, a write replaces one half and skips the increment
    always_comb begin
        cnt_d = cnt_q + 64'd1;
        if (do_write && (csr_addr == A_MCYCLE)) begin
            cnt_d              = cnt_q;
            cnt_d[XLEN-1:0]    = wval;
        end else if (do_write && (csr_addr == A_MCYCLEH)) begin
            cnt_d = {wval[31:0], cnt_q[31:0]};
        end
    end

    // counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`endif

    // architectural CSR registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= {MTVEC_RST[XLEN-1:2], 2'b00};
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
        end
    end

endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit: directed-vector bench for csr_unit (XLEN = 32).
// Exercises mcycle when built with CSR_MCYCLE_EN, otherwise checks it is absent.
`timescale 1ns/1ps
module tb_csr_unit;

    localparam logic [31:0] ARCH = 32'h0000_0ABC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        csr_req;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        trap_valid;
    logic [31:0] trap_pc;
    logic [31:0] trap_cause;
    logic        mret_valid;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mie_o;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [31:0] v;
    logic        ill;

    csr_unit #(
        .XLEN      (32),
        .MTVEC_RST (32'h8000_0000),
        .MARCHID   (ARCH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .csr_req        (csr_req),
        .csr_op         (csr_op),
        .csr_addr       (csr_addr),
        .csr_wdata      (csr_wdata),
        .csr_rdata      (csr_rdata),
        .csr_illegal    (csr_illegal),
        .trap_valid     (trap_valid),
        .trap_pc        (trap_pc),
        .trap_cause     (trap_cause),
        .mret_valid     (mret_valid),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mie_o          (mie_o)
    );

    always #10 clk = ~clk;

    task automatic idle();
        csr_req = 1'b0; csr_op = 2'b00; csr_addr = '0; csr_wdata = '0;
        trap_valid = 1'b0; trap_pc = '0; trap_cause = '0; mret_valid = 1'b0;
    endtask

    // commit one posedge, return to the following negedge with inputs idle
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        idle();
    endtask

    // non-writing read (op 00), sampled 1 ns after applying the address
    task automatic rd(input logic [11:0] a, output logic [31:0] val, output logic il);
        csr_req = 1'b1; csr_op = 2'b00; csr_addr = a; csr_wdata = '0;
        #1;
        val = csr_rdata;
        il  = csr_illegal;
        csr_req = 1'b0;
    endtask

    task automatic drive_op(input logic [1:0] o, input logic [11:0] a, input logic [31:0] d);
        csr_req = 1'b1; csr_op = o; csr_addr = a; csr_wdata = d;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        trap_valid = 1'b1; mret_valid = 1'b1;
        #1;
        n_cmp++; if (redirect_valid !== 1'b0) begin n_bad++; $display("FAIL rst_redirect_valid: got %b want 0", redirect_valid); end
        n_cmp++; if (mie_o !== 1'b0) begin n_bad++; $display("FAIL rst_mie: got %b want 0", mie_o); end
        n_cmp++; if (csr_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata_noreq: got %h want 0", csr_rdata); end
        idle();
        csr_req = 1'b1; csr_op = 2'b01; csr_addr = 12'h7C0; csr_wdata = 32'h1;
        #1;
        n_cmp++; if (csr_illegal !== 1'b0) begin n_bad++; $display("FAIL rst_illegal: got %b want 0", csr_illegal); end
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        rd(12'h305, v, ill);
        n_cmp++; if (v !== 32'h8000_0000) begin n_bad++; $display("FAIL rst_mtvec: got %h want 80000000", v); end
        rd(12'h300, v, ill);
        n_cmp++; if (v !== 32'h0000_1800) begin n_bad++; $display("FAIL rst_mstatus: got %h want 00001800", v); end
        rd(12'h341, v, ill);
        n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL rst_mepc: got %h want 0", v); end
        n_cmp++; if (redirect_valid !== 1'b0) begin n_bad++; $display("FAIL rst_redirect_idle: got %b want 0", redirect_valid); end
        step();
    endtask

    task automatic test_rw_rs_rc();
        drive_op(2'b01, 12'h340, 32'hDEAD_BEEF);
        step();
        rd(12'h340, v, ill);
        n_cmp++; if (v !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL mscratch_rw: got %h want deadbeef", v); end
        drive_op(2'b10, 12'h340, 32'h0000_0010);
        #1;
        n_cmp++; if (csr_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rs_old_value: got %h want deadbeef", csr_rdata); end
        step();
        rd(12'h340, v, ill);
        n_cmp++; if (v !== 32'hDEAD_BEFF) begin n_bad++; $display("FAIL mscratch_rs: got %h want deadbeff", v); end
        drive_op(2'b11, 12'h340, 32'h0000_000F);
        step();
        rd(12'h340, v, ill);
        n_cmp++; if (v !== 32'hDEAD_BEF0) begin n_bad++; $display("FAIL mscratch_rc: got %h want deadbef0", v); end
        drive_op(2'b01, 12'h342, 32'h0000_0007);
        step();
        drive_op(2'b11, 12'h342, 32'h0);
        step();
        rd(12'h342, v, ill);
        n_cmp++; if (v !== 32'h7) begin n_bad++; $display("FAIL rc_zero_nowrite: got %h want 7", v); end
    endtask

    task automatic test_trap();
        drive_op(2'b10, 12'h300, 32'h0000_0008);
        step();
        rd(12'h300, v, ill);
        n_cmp++; if (v !== 32'h0000_1808) begin n_bad++; $display("FAIL mstatus_set_mie: got %h want 00001808", v); end
        n_cmp++; if (mie_o !== 1'b1) begin n_bad++; $display("FAIL mie_o_set: got %b want 1", mie_o); end
        trap_valid = 1'b1; trap_pc = 32'h8000_0106; trap_cause = 32'd11;
        #1;
        n_cmp++; if (redirect_valid !== 1'b1) begin n_bad++; $display("FAIL trap_redirect_valid: got %b want 1", redirect_valid); end
        n_cmp++; if (redirect_pc !== 32'h8000_0000) begin n_bad++; $display("FAIL trap_redirect_pc: got %h want 80000000", redirect_pc); end
        step();
        rd(12'h341, v, ill);
        n_cmp++; if (v !== 32'h8000_0104) begin n_bad++; $display("FAIL trap_mepc: got %h want 80000104", v); end
        rd(12'h342, v, ill);
        n_cmp++; if (v !== 32'd11) begin n_bad++; $display("FAIL trap_mcause: got %h want 0000000b", v); end
        rd(12'h300, v, ill);
        n_cmp++; if (v !== 32'h0000_1880) begin n_bad++; $display("FAIL trap_mstatus: got %h want 00001880", v); end
        step();
    endtask

    task automatic test_mret();
        mret_valid = 1'b1;
        #1;
        n_cmp++; if (redirect_pc !== 32'h8000_0104) begin n_bad++; $display("FAIL mret_redirect_pc: got %h want 80000104", redirect_pc); end
        n_cmp++; if (redirect_valid !== 1'b1) begin n_bad++; $display("FAIL mret_redirect_valid: got %b want 1", redirect_valid); end
        step();
        rd(12'h300, v, ill);
        n_cmp++; if (v !== 32'h0000_1888) begin n_bad++; $display("FAIL mret_mstatus: got %h want 00001888", v); end
        n_cmp++; if (mie_o !== 1'b1) begin n_bad++; $display("FAIL mret_mie_o: got %b want 1", mie_o); end
    endtask

    task automatic test_illegal();
        drive_op(2'b01, 12'hF11, 32'h5);
        #1;
        n_cmp++; if (csr_illegal !== 1'b1) begin n_bad++; $display("FAIL rw_mvendorid_illegal: got %b want 1", csr_illegal); end
        step();
        rd(12'hF11, v, ill);
        n_cmp++; if (v !== 32'h0 || ill !== 1'b0) begin n_bad++; $display("FAIL mvendorid_read: got %h/%b want 0/0", v, ill); end
        drive_op(2'b10, 12'hF12, 32'h0);
        #1;
        n_cmp++; if (csr_illegal !== 1'b0 || csr_rdata !== ARCH) begin n_bad++; $display("FAIL rs0_marchid: got %h/%b want %h/0", csr_rdata, csr_illegal, ARCH); end
        drive_op(2'b11, 12'hF12, 32'h1);
        #1;
        n_cmp++; if (csr_illegal !== 1'b1) begin n_bad++; $display("FAIL rc1_marchid_illegal: got %b want 1", csr_illegal); end
        drive_op(2'b01, 12'h7C0, 32'hFFFF_FFFF);
        #1;
        n_cmp++; if (csr_illegal !== 1'b1 || csr_rdata !== 32'h0) begin n_bad++; $display("FAIL addr_7c0: got %h/%b want 0/1", csr_rdata, csr_illegal); end
        step();
    endtask

    task automatic test_priority();
        drive_op(2'b01, 12'h305, 32'h0000_2003);
        step();
        rd(12'h305, v, ill);
        n_cmp++; if (v !== 32'h0000_2000) begin n_bad++; $display("FAIL mtvec_write: got %h want 00002000", v); end
        drive_op(2'b01, 12'h340, 32'h1234_5678);
        trap_valid = 1'b1; mret_valid = 1'b1; trap_pc = 32'h0000_0203; trap_cause = 32'd2;
        #1;
        n_cmp++; if (redirect_pc !== 32'h0000_2000) begin n_bad++; $display("FAIL trap_over_mret_pc: got %h want 00002000", redirect_pc); end
        n_cmp++; if (csr_rdata !== 32'hDEAD_BEF0) begin n_bad++; $display("FAIL prio_rdata_old: got %h want deadbef0", csr_rdata); end
        step();
        rd(12'h340, v, ill);
        n_cmp++; if (v !== 32'hDEAD_BEF0) begin n_bad++; $display("FAIL trap_drops_write: got %h want deadbef0", v); end
        rd(12'h300, v, ill);
        n_cmp++; if (v !== 32'h0000_1880) begin n_bad++; $display("FAIL trap_drops_mret: got %h want 00001880", v); end
        rd(12'h341, v, ill);
        n_cmp++; if (v !== 32'h0000_0200) begin n_bad++; $display("FAIL prio_mepc: got %h want 00000200", v); end
        drive_op(2'b01, 12'h340, 32'h1111_1111);
        mret_valid = 1'b1;
        step();
        rd(12'h340, v, ill);
        n_cmp++; if (v !== 32'hDEAD_BEF0) begin n_bad++; $display("FAIL mret_drops_write: got %h want deadbef0", v); end
        rd(12'h300, v, ill);
        n_cmp++; if (v !== 32'h0000_1888) begin n_bad++; $display("FAIL mret_after_trap: got %h want 00001888", v); end
    endtask

    task automatic test_back_to_back();
        drive_op(2'b01, 12'h341, 32'h0000_3007);
        mret_valid = 1'b0;
        #1;
        n_cmp++; if (redirect_pc !== 32'h0000_0200) begin n_bad++; $display("FAIL mepc_pre_edge: got %h want 00000200", redirect_pc); end
        step();
        mret_valid = 1'b1;
        #1;
        n_cmp++; if (redirect_pc !== 32'h0000_3004) begin n_bad++; $display("FAIL mepc_next_cycle: got %h want 00003004", redirect_pc); end
        step();
    endtask

    task automatic test_mcycle();
`ifdef CSR_MCYCLE_EN
        drive_op(2'b01, 12'hB00, 32'hFFFF_FFFF);
        step();
        rd(12'hB00, v, ill);
        n_cmp++; if (v !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mcycle_write: got %h want ffffffff", v); end
        rd(12'hB80, v, ill);
        n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL mcycleh_before: got %h want 0", v); end
        step();
        rd(12'hB00, v, ill);
        n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL mcycle_wrap: got %h want 0", v); end
        rd(12'hB80, v, ill);
        n_cmp++; if (v !== 32'h1) begin n_bad++; $display("FAIL mcycleh_carry: got %h want 1", v); end
        drive_op(2'b01, 12'hB00, 32'h55);
        trap_valid = 1'b1; trap_pc = 32'h100; trap_cause = 32'd3;
        step();
        rd(12'hB00, v, ill);
        n_cmp++; if (v !== 32'h1) begin n_bad++; $display("FAIL trap_drops_mcycle_write: got %h want 1", v); end
        drive_op(2'b01, 12'hB80, 32'h7);
        step();
        rd(12'hB80, v, ill);
        n_cmp++; if (v !== 32'h7) begin n_bad++; $display("FAIL mcycleh_write: got %h want 7", v); end
        rd(12'hB00, v, ill);
        n_cmp++; if (v !== 32'h1) begin n_bad++; $display("FAIL mcycle_hold_on_h_write: got %h want 1", v); end
        step();
`else
        rd(12'hB00, v, ill);
        n_cmp++; if (ill !== 1'b1 || v !== 32'h0) begin n_bad++; $display("FAIL mcycle_absent: got %h/%b want 0/1", v, ill); end
        rd(12'hB80, v, ill);
        n_cmp++; if (ill !== 1'b1 || v !== 32'h0) begin n_bad++; $display("FAIL mcycleh_absent: got %h/%b want 0/1", v, ill); end
        step();
`endif
    endtask

    task automatic test_async_reset();
        #3;
        rst_n = 1'b0;
        #1;
        rd(12'h340, v, ill);
        n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL async_rst_mscratch: got %h want 0", v); end
        rd(12'h305, v, ill);
        n_cmp++; if (v !== 32'h8000_0000) begin n_bad++; $display("FAIL async_rst_mtvec: got %h want 80000000", v); end
        n_cmp++; if (mie_o !== 1'b0) begin n_bad++; $display("FAIL async_rst_mie: got %b want 0", mie_o); end
        drive_op(2'b01, 12'h340, 32'hAAAA_AAAA);
        @(posedge clk);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        #1;
        rd(12'h340, v, ill);
        n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL rst_drops_request: got %h want 0", v); end
    endtask

    initial begin
        test_reset();
        test_rw_rs_rc();
        test_trap();
        test_mret();
        test_illegal();
        test_priority();
        test_back_to_back();
        test_mcycle();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
